// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder.
// Imported by bcd_digit_add and bcd_serial_add_ctrl.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ADD,
    DONE
  } state_t;

  localparam int         BCD_DIGIT_W    = 4;
  localparam logic [3:0] BCD_MAX_DIGIT  = 4'd9;
  localparam logic [3:0] BCD_CORRECTION = 4'd6;

endpackage

// File: rtl/bcd_digit_add.sv
// Combinational single-digit BCD adder cell with decimal correction.
// Also flags operand digits outside 0..9.
module bcd_digit_add
  import bcd_pkg::*;
(
  input  logic [3:0] x,
  input  logic [3:0] y,
  input  logic       ci,
  output logic [3:0] d,
  output logic       co,
  output logic       invalid
);

  logic [4:0] t;
  logic [4:0] tc;

  assign t  = {1'b0, x} + {1'b0, y} + {4'b0, ci};
  assign tc = t + {1'b0, BCD_CORRECTION};

  always_comb begin
    d  = t[3:0];
    co = 1'b0;
    if (t > {1'b0, BCD_MAX_DIGIT}) begin
      d  = tc[3:0];
      co = 1'b1;
    end
  end

  assign invalid = (x > BCD_MAX_DIGIT) |
                   (y > BCD_MAX_DIGIT);

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Digit-serial packed-BCD adder sequencer, LSD first, one digit/clock.
// Optional invalid-digit flag: define BCD_DIGIT_CHECK_EN.
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4*NDIGITS-1:0]  a,
  input  logic [4*NDIGITS-1:0]  b,
  input  logic                  cin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*NDIGITS-1:0]  s,
  output logic                  cout,
  output logic                  busy
`ifdef BCD_DIGIT_CHECK_EN
  ,
  output logic                  err
`endif
);

  localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam int W  = BCD_DIGIT_W * NDIGITS;
  localparam logic [IW-1:0] LAST = IW'(NDIGITS - 1);

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_r;
  logic [W-1:0]  b_r;

  logic [3:0]    xd;
  logic [3:0]    yd;
  logic [3:0]    dd;
  logic          co;

  assign xd = a_r[BCD_DIGIT_W*idx +: BCD_DIGIT_W];
  assign yd = b_r[BCD_DIGIT_W*idx +: BCD_DIGIT_W];

`ifdef BCD_DIGIT_CHECK_EN
  logic inv;
`else
  logic inv_unused;
`endif

  bcd_digit_add u_cell (
    .x       (xd),
    .y       (yd),
    .ci      (carry),
    .d       (dd),
    .co      (co),
`ifdef BCD_DIGIT_CHECK_EN
    .invalid (inv)
`else
    .invalid (inv_unused)
`endif
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      s         <= '0;
      cout      <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
      err       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            carry    <= cin;
            idx      <= '0;
            s        <= '0;
            cout     <= 1'b0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ADD;
`ifdef BCD_DIGIT_CHECK_EN
            err      <= 1'b0;
`endif
          end
        end
        ADD: begin
          s[BCD_DIGIT_W*idx +: BCD_DIGIT_W] <= dd;
          carry <= co;
`ifdef BCD_DIGIT_CHECK_EN
          err   <= err | inv;
`endif
          if (idx == LAST) begin
            cout      <= co;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          // s/cout hold their value until the consumer takes them
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// Randomized self-checking bench for bcd_serial_add_ctrl.
// Reference model works on decimal integers, not digit logic.
module tb_bcd_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] a;
  logic [11:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] s;
  logic        cout;
  logic        busy;

  logic        in_valid1;
  logic        in_ready1;
  logic [3:0]  a1;
  logic [3:0]  b1;
  logic        cin1;
  logic        out_valid1;
  logic        out_ready1;
  logic [3:0]  s1;
  logic        cout1;
  logic        busy1;

`ifdef BCD_DIGIT_CHECK_EN
  logic        err;
  logic        err1;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_serial_add_ctrl #(.NDIGITS(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout),
`ifdef BCD_DIGIT_CHECK_EN
    .busy      (busy),
    .err       (err)
`else
    .busy      (busy)
`endif
  );

  bcd_serial_add_ctrl #(.NDIGITS(1)) dut1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .s         (s1),
    .cout      (cout1),
`ifdef BCD_DIGIT_CHECK_EN
    .busy      (busy1),
    .err       (err1)
`else
    .busy      (busy1)
`endif
  );

  task automatic check(string tag, logic [31:0] got,
                       logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int bcd2int(logic [31:0] v, int n);
    int r = 0;
    for (int i = n - 1; i >= 0; i--)
      r = r * 10 + int'((v >> (4 * i)) & 32'hF);
    return r;
  endfunction

  function automatic logic [31:0] int2bcd(int x, int n);
    logic [31:0] r = '0;
    int v = x;
    for (int i = 0; i < n; i++) begin
      r = r | (32'(v % 10) << (4 * i));
      v = v / 10;
    end
    return r;
  endfunction

  // returns {cout, sum digits}
  function automatic logic [32:0] ref_add(logic [31:0] x,
                                          logic [31:0] y,
                                          logic c, int n);
    int lim = 1;
    int sum;
    for (int i = 0; i < n; i++) lim = lim * 10;
    sum = bcd2int(x, n) + bcd2int(y, n) + int'(c);
    return {sum >= lim, int2bcd(sum % lim, n)};
  endfunction

  task automatic run(logic [11:0] ta, logic [11:0] tb_,
                     logic tc, logic [11:0] es, logic eco,
                     int hold, bit pre, bit poke, bit ee);
    int cyc;
    logic [11:0] ss;
    logic        sc;
    check("rdy_idle", 32'(in_ready), 32'd1);
    a = ta; b = tb_; cin = tc; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 12'($urandom); b = 12'($urandom); cin = 1'b1;
    if (pre) out_ready = 1'b1;
    check("rdy_acc", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!out_valid && cyc < 16) begin
      check("busy", 32'(busy), 32'd1);
      check("rdy_add", 32'(in_ready), 32'd0);
      if (poke && cyc == 0) begin
        in_valid = 1'b1;
        a = 12'h888; b = 12'h111;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc++;
    end
    check("latency", 32'(cyc), 32'd3);
    check("sum", 32'(s), 32'(es));
    check("cout", 32'(cout), 32'(eco));
    check("busy_done", 32'(busy), 32'd0);
    check("rdy_done", 32'(in_ready), 32'd0);
`ifdef BCD_DIGIT_CHECK_EN
    check("err", 32'(err), 32'(ee));
`else
    if (ee) check("ee_unused", 32'(busy), 32'd0);
`endif
    ss = s; sc = cout;
    if (!pre) begin
      for (int i = 0; i < hold; i++) begin
        @(posedge clk); #1;
        check("ov_hold", 32'(out_valid), 32'd1);
        check("s_hold", 32'(s), 32'(ss));
        check("c_hold", 32'(cout), 32'(sc));
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("ov_taken", 32'(out_valid), 32'd0);
    check("rdy_back", 32'(in_ready), 32'd1);
  endtask

  task automatic run_rand();
    logic [11:0] x;
    logic [11:0] y;
    logic        c;
    logic [32:0] r;
    x = 12'(int2bcd($urandom_range(0, 999), 3));
    y = 12'(int2bcd($urandom_range(0, 999), 3));
    c = 1'($urandom_range(0, 1));
    r = ref_add(32'(x), 32'(y), c, 3);
    run(x, y, c, r[11:0], r[32], $urandom_range(0, 3),
        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
  endtask

  task automatic run1(logic [3:0] x, logic [3:0] y, logic c);
    logic [32:0] r;
    int cyc;
    r = ref_add(32'(x), 32'(y), c, 1);
    a1 = x; b1 = y; cin1 = c; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    cyc = 0;
    while (!out_valid1 && cyc < 8) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat1", 32'(cyc), 32'd1);
    check("sum1", 32'(s1), r[31:0]);
    check("cout1", 32'(cout1), 32'(r[32]));
    out_ready1 = 1'b1;
    @(posedge clk); #1;
    out_ready1 = 1'b0;
    check("ov1_taken", 32'(out_valid1), 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
    out_ready = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
    out_ready1 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rdy", 32'(in_ready), 32'd1);
    check("rst_ov", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_s", 32'(s), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
`ifdef BCD_DIGIT_CHECK_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst = 1'b0;
    @(posedge clk); #1;

    run(12'h499, 12'h490, 1'b0, 12'h989, 1'b0, 0, 0, 0, 0);
    run(12'h999, 12'h001, 1'b0, 12'h000, 1'b1, 1, 0, 0, 0);
    run(12'h007, 12'h004, 1'b1, 12'h012, 1'b0, 0, 0, 1, 0);
    // digit 0 of b is 0xC: 1+12 -> 13 -> corrected 3, carry 1
    run(12'h111, 12'h21C, 1'b0, 12'h333, 1'b0, 5, 0, 0, 1);
    run(12'h500, 12'h500, 1'b0, 12'h000, 1'b1, 0, 1, 0, 0);

    // abort mid-operation
    a = 12'h555; b = 12'h555; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_rdy", 32'(in_ready), 32'd1);
    check("abort_ov", 32'(out_valid), 32'd0);
    check("abort_s", 32'(s), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    check("abort_ov2", 32'(out_valid), 32'd0);
    run(12'h123, 12'h456, 1'b0, 12'h579, 1'b0, 0, 0, 0, 0);

    for (int k = 0; k < 25; k++) run_rand();

    run1(4'h9, 4'h9, 1'b1);
    for (int k = 0; k < 8; k++)
      run1(4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
           1'($urandom_range(0, 1)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_serial_add_ctrl.md
# bcd_serial_add_ctrl

Sequencer that performs an NDIGITS-digit packed-BCD addition by time-multiplexing one single-digit BCD adder cell, least-significant digit first, one digit per clock. It sits between a requester and the result consumer with valid/ready handshakes on both sides. It is the area-reduced alternative to the fully parallel N-digit BCD adder: same operand and result format, with N cycles of latency instead of zero.

## Interface
- NDIGITS, 3: number of BCD digits per operand; must be ≥1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset; synchronous, active-high.
- in_valid  input  1  operand request.
- in_ready  output  1  controller can accept operands.
- a  input  4*NDIGITS  packed BCD operand A; digit 0 is in bits [3:0].
- b  input  4*NDIGITS  packed BCD operand B.
- cin  input  1  carry into digit 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts the result.
- s  output  4*NDIGITS  packed BCD sum.
- cout  output  1  carry out of the most significant digit.
- busy  output  1  high in ADD state.
- err  output  1  invalid-digit flag; present only with BCD_DIGIT_CHECK_EN.

## Operation
- States: IDLE, ADD, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready: latch a, b and cin; clear the digit index and the sum register; go to ADD.
- ADD, one digit per cycle at index i:
  - Compute t = a_i + b_i + c as a 5-bit value, where c is the running carry (max 19).
  - If t > 9: digit = (t + 6)[3:0] and carry = 1. Otherwise digit = t[3:0] and carry = 0.
  - Write the digit into s[4i+3:4i] and update the running carry.
  - When i == NDIGITS-1, set cout to the final carry and go to DONE. Otherwise increment i.
- DONE:
  - out_valid=1.
  - s and cout stay stable until out_valid && out_ready, then go to IDLE.
  - No operand acceptance in DONE; in_ready=0.
- in_valid in ADD or DONE is ignored. The requester must hold in_valid until it sees in_ready.
- Latched operands are unaffected by input changes after acceptance.
- Index counter width is $clog2(NDIGITS), minimum 1 bit.

## Timing
- Reset values:
  - State = IDLE, so in_ready=1.
  - out_valid=0, busy=0, s=0, cout=0, err=0, index=0, running carry=0.
- Latency: operands accepted on edge k produce out_valid=1 after edge k+NDIGITS.
- Throughput: one addition per NDIGITS+2 cycles at best (accept, N digit cycles, DONE handshake, IDLE re-accept).
- NDIGITS=1: exactly one ADD cycle.
- out_ready held high before out_valid rises: the result is consumed on the first DONE cycle.
- rst asserted in any state, including mid-ADD, aborts the operation on that edge. All outputs return to their reset values and no partial result is presented.

## Configuration
- BCD_DIGIT_CHECK_EN defined:
  - During the ADD cycle of each digit, check a_i > 9 or b_i > 9.
  - Any hit sets the sticky err, which is valid with out_valid.
  - err clears on the next accept or on rst.
  - The sum is still computed with the normal rule.
- BCD_DIGIT_CHECK_EN undefined: the err port and its logic are absent, and invalid digits produce unspecified-but-deterministic sums.

## Structure
- Shared package bcd_pkg holds:
  - The state enum (IDLE/ADD/DONE).
  - BCD_DIGIT_W = 4.
  - BCD_MAX_DIGIT = 9.
  - BCD_CORRECTION = 6.
- Sub-module bcd_digit_add: purely combinational single-digit cell.
  - Inputs: 4-bit x, 4-bit y, 1-bit ci.
  - Outputs: 4-bit d, 1-bit co, and 1-bit invalid (used only under the macro).
- The top level holds the FSM, the index counter, the carry register and the sum register.

## Test plan
- a=0x499, b=0x490, cin=0: s=0x989, cout=0; out_valid rises 3 cycles after acceptance.
- a=0x999, b=0x001, cin=0: s=0x000, cout=1, exercising the full carry ripple across all digits.
- a=0x007, b=0x004, cin=1: s=0x012, cout=0; a second request issued while busy is ignored and in_ready stays 0.
- Backpressure, a=0x111, b=0x21C: hold out_ready=0 for 5 cycles; s, cout and out_valid stay stable; the result is consumed on the cycle out_ready rises, then in_ready=1 next cycle.
  - With BCD_DIGIT_CHECK_EN: the same case reports err=1 because digit 0 of b is 0xC.
- Assert rst after the second ADD cycle: next cycle state=IDLE, out_valid=0, s=0, cout=0. A subsequent 0x123+0x456 yields 0x579.
- NDIGITS=1, a=0x9, b=0x9, cin=1: s=0x9, cout=1, latency 1 cycle.
